// File: rtl/bus_arbiter_mc_pkg.sv
// Shared types for the multi-channel bus arbiter: opcodes, busio register
// indices, sequencer states and small opcode classification helpers.
package bus_arbiter_mc_pkg;

   typedef enum logic [3:0] {
      OP_FETCH = 4'd8,
      OP_DRD   = 4'd9,
      OP_DWR   = 4'd10,
      OP_RDMWR = 4'd11,
      OP_BTRWR = 4'd12,
      OP_BTRRD = 4'd13,
      OP_BIRD  = 4'd15
   } opcode_e;

   typedef enum logic [1:0] {
      REG_ADDR  = 2'd0,
      REG_CMD   = 2'd1,
      REG_RDATA = 2'd2,
      REG_WDATA = 2'd3
   } reg_index_e;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ADDR,
      S_SETUP,
      S_STROBE,
      S_FIN
   } state_e;

   // Opcodes 0-7 and 14 complete without touching the bus.
   function automatic logic op_uses_bus(input logic [3:0] op);
      return (op >= 4'd8) && (op != 4'd14);
   endfunction

   function automatic logic op_is_burst(input logic [3:0] op);
      return (op == OP_BTRWR) || (op == OP_BTRRD);
   endfunction

endpackage

// File: rtl/bus_arbiter_mc_rr_arbiter.sv
// Round-robin grant over NCH requesters; the search starts one past the
// last channel that was actually taken, channel 0 first after reset.
module rr_arbiter #(
   parameter int NCH = 2
) (
   input  logic           clk,
   input  logic           reset,
   input  logic [NCH-1:0] req,
   input  logic           take,
   output logic [NCH-1:0] grant
);

   localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;

   logic [IW-1:0] ptr_reg;
   logic [IW-1:0] ptr_next;
   logic [IW-1:0] win_idx;
   logic          found;

   function automatic int wrap(input int v);
      return v % NCH;
   endfunction

   always_comb begin
      grant   = '0;
      found   = 1'b0;
      win_idx = '0;
      for (int k = 0; k < NCH; k++) begin
         if (!found && req[wrap(int'(ptr_reg) + k)]) begin
            found = 1'b1;
            grant[wrap(int'(ptr_reg) + k)] = 1'b1;
            win_idx = IW'(wrap(int'(ptr_reg) + k));
         end
      end
   end

   assign ptr_next = (win_idx == IW'(NCH - 1)) ? '0 : win_idx + IW'(1);

   always_ff @(posedge clk) begin
      if (reset) begin
         ptr_reg <= '0;
      end else if (take && found) begin
         ptr_reg <= ptr_next;
      end
   end

endmodule

// File: rtl/bus_arbiter_mc.sv
// Multi-channel bus arbiter: grants one requesting channel at a time and
// sequences its opcode into busio/memory strobes with wait-state timeout.
module bus_arbiter_mc
   import bus_arbiter_mc_pkg::*;
#(
   parameter int NCH   = 2,
   parameter int BURST = 4,
   parameter int TMO   = 255
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [NCH-1:0]      req,
   input  logic [NCH-1:0][3:0] req_op,
   input  logic                suspend,
   input  logic                mem_ready,
   output logic [NCH-1:0]      gnt,
   output logic [1:0]          arx,
   output logic                ecx,
   output logic                wrx,
   output logic                astb,
   output logic                rd,
   output logic                wr,
   output logic                iack,
   output logic                atomic,
   output logic [NCH-1:0]      done,
   output logic                err
);

   localparam int              WCW        = (TMO < 1) ? 1 : $clog2(TMO + 1);
   localparam logic [3:0]      BURST_LAST = 4'(BURST - 1);
   localparam logic [WCW-1:0]  TMO_CNT    = WCW'(TMO);

   state_e           state_reg, state_next;
   logic [NCH-1:0]   gnt_reg, gnt_next;
   logic [3:0]       op_reg, op_next;
   logic [3:0]       word_cnt_reg, word_cnt_next;
   logic [WCW-1:0]   wait_cnt_reg, wait_cnt_next;
   logic             err_reg, err_next;

   logic [NCH-1:0]   arb_grant;
   logic             arb_take;
   logic [3:0]       sel_op;
   logic             write_phase;
   logic             is_rdmwr;
   logic             fin_out;
   reg_index_e       arx_idx;

   assign arb_take = (state_reg == S_IDLE) && !suspend && (|req);

   rr_arbiter #(.NCH(NCH)) u_rr_arbiter (
      .clk   (clk),
      .reset (reset),
      .req   (req),
      .take  (arb_take),
      .grant (arb_grant)
   );

   always_comb begin
      sel_op = '0;
      for (int i = 0; i < NCH; i++) begin
         if (arb_grant[i]) sel_op = sel_op | req_op[i];
      end
   end

   // RDMWR runs its read half with word_cnt=1 and its write half at 0.
   assign is_rdmwr    = (op_reg == OP_RDMWR);
   assign write_phase = (op_reg == OP_DWR) || (op_reg == OP_BTRWR) ||
                        (is_rdmwr && (word_cnt_reg == 4'd0));

   always_comb begin
      state_next    = state_reg;
      gnt_next      = gnt_reg;
      op_next       = op_reg;
      word_cnt_next = word_cnt_reg;
      wait_cnt_next = wait_cnt_reg;
      err_next      = err_reg;
      case (state_reg)
         S_IDLE: begin
            err_next = 1'b0;
            if (|req) begin
               gnt_next      = arb_grant;
               op_next       = sel_op;
               wait_cnt_next = '0;
               if (op_is_burst(sel_op))      word_cnt_next = BURST_LAST;
               else if (sel_op == OP_RDMWR)  word_cnt_next = 4'd1;
               else                          word_cnt_next = 4'd0;
               if (!op_uses_bus(sel_op))     state_next = S_FIN;
               else if (sel_op == OP_BIRD)   state_next = S_SETUP;
               else                          state_next = S_ADDR;
            end
         end
         S_ADDR: state_next = S_SETUP;
         S_SETUP: begin
            wait_cnt_next = '0;
            state_next    = S_STROBE;
         end
         S_STROBE: begin
            if (mem_ready) begin
               if (word_cnt_reg == 4'd0) begin
                  state_next = S_FIN;
               end else begin
                  word_cnt_next = word_cnt_reg - 4'd1;
                  state_next    = S_SETUP;
               end
            end else if (wait_cnt_reg == TMO_CNT) begin
               err_next   = 1'b1;
               state_next = S_FIN;
            end else begin
               wait_cnt_next = wait_cnt_reg + WCW'(1);
            end
         end
         S_FIN: begin
            gnt_next   = '0;
            err_next   = 1'b0;
            state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
      if (suspend) begin
         state_next = S_IDLE;
         gnt_next   = '0;
         err_next   = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg    <= S_IDLE;
         gnt_reg      <= '0;
         op_reg       <= '0;
         word_cnt_reg <= '0;
         wait_cnt_reg <= '0;
         err_reg      <= 1'b0;
      end else begin
         state_reg    <= state_next;
         gnt_reg      <= gnt_next;
         op_reg       <= op_next;
         word_cnt_reg <= word_cnt_next;
         wait_cnt_reg <= wait_cnt_next;
         err_reg      <= err_next;
      end
   end

   always_comb begin
      arx_idx = REG_RDATA;
      ecx     = 1'b0;
      astb    = 1'b0;
      rd      = 1'b0;
      wr      = 1'b0;
      wrx     = 1'b0;
      iack    = 1'b0;
      atomic  = 1'b0;
      case (state_reg)
         S_ADDR: begin
            arx_idx = REG_ADDR;
            ecx     = 1'b1;
            astb    = 1'b1;
            atomic  = is_rdmwr;
         end
         S_SETUP, S_STROBE: begin
            ecx    = 1'b1;
            atomic = is_rdmwr;
            iack   = (op_reg == OP_BIRD);
            if (op_reg == OP_FETCH)             arx_idx = REG_CMD;
            else if (write_phase && !is_rdmwr)  arx_idx = REG_WDATA;
            else                                arx_idx = REG_RDATA;
            if (state_reg == S_SETUP) begin
               rd = !write_phase;
            end else begin
               wrx = !write_phase;
               wr  = write_phase;
            end
         end
         default: ;
      endcase
   end

   assign arx     = arx_idx;
   assign gnt     = gnt_reg;
   assign fin_out = (state_reg == S_FIN) && !suspend;
   assign err     = fin_out && err_reg;

   generate
      for (genvar gi = 0; gi < NCH; gi++) begin : g_done
         assign done[gi] = fin_out && gnt_reg[gi];
      end
   endgenerate

endmodule

// File: tb/tb_bus_arbiter_mc.sv
// Directed bench: expected per-op outcomes are queued as each op is issued
// and popped when the granted channel's done pulse appears.
module tb_bus_arbiter_mc;
   import bus_arbiter_mc_pkg::*;

   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic [1:0]      req = '0;
   logic [1:0][3:0] req_op = '0;
   logic            suspend = 1'b0;
   logic            mem_ready = 1'b1;
   logic [1:0]      gnt;
   logic [1:0]      arx;
   logic            ecx, wrx, astb, rd, wr, iack, atomic;
   logic [1:0]      done;
   logic            err;

   bus_arbiter_mc #(.NCH(2), .BURST(4), .TMO(255)) dut (
      .clk       (clk),
      .reset     (reset),
      .req       (req),
      .req_op    (req_op),
      .suspend   (suspend),
      .mem_ready (mem_ready),
      .gnt       (gnt),
      .arx       (arx),
      .ecx       (ecx),
      .wrx       (wrx),
      .astb      (astb),
      .rd        (rd),
      .wr        (wr),
      .iack      (iack),
      .atomic    (atomic),
      .done      (done),
      .err       (err)
   );

   always #5 clk = ~clk;

   typedef struct {
      string tag;
      int cyc; int dn; int er;
      int astb; int rd; int wr; int wrx; int ecx; int atomic; int iack; int gnt_or;
   } rec_t;

   rec_t sb_q[$];
   int   total = 0;
   int   bad = 0;
   bit   force_low = 1'b0;
   int   stall_left = 0;
   logic [1:0] dacc;

   function automatic rec_t mk(string tag, int cyc, int dn, int er, int a, int r, int w,
                               int x, int e, int at, int ia, int g);
      rec_t t;
      t.tag = tag; t.cyc = cyc; t.dn = dn; t.er = er; t.astb = a; t.rd = r; t.wr = w;
      t.wrx = x; t.ecx = e; t.atomic = at; t.iack = ia; t.gnt_or = g;
      return t;
   endfunction

   task automatic check(input string name, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", name, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start(input logic [1:0] r, input logic [3:0] o0, input logic [3:0] o1);
      req_op[0] = o0;
      req_op[1] = o1;
      req       = r;
   endtask

   // Samples each cycle (cycle 0 = current) until done or budget expiry.
   task automatic collect(input int budget, output rec_t o);
      bit fin;
      bit strobe_now;
      fin = 1'b0;
      o = mk("", -1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      for (int n = 0; n <= budget && !fin; n++) begin
         o.astb   += int'(astb);
         o.rd     += int'(rd);
         o.wr     += int'(wr);
         o.wrx    += int'(wrx);
         o.ecx    += int'(ecx);
         o.atomic += int'(atomic);
         o.iack   += int'(iack);
         if (n >= 1) o.gnt_or = o.gnt_or | int'(gnt);
         if (done != 2'b00) begin
            fin   = 1'b1;
            o.cyc = n;
            o.dn  = int'(done);
            o.er  = int'(err);
            req   = req & ~done;
         end else begin
            strobe_now = wr | wrx;
            mem_ready  = !(force_low || (stall_left > 0 && strobe_now));
            if (strobe_now && !mem_ready && stall_left > 0) stall_left--;
            tick();
         end
      end
   endtask

   task automatic verify(input int budget);
      rec_t o, e;
      collect(budget, o);
      e = sb_q.pop_front();
      check({e.tag, ".cyc"},    o.cyc,    e.cyc);
      check({e.tag, ".done"},   o.dn,     e.dn);
      check({e.tag, ".err"},    o.er,     e.er);
      check({e.tag, ".astb"},   o.astb,   e.astb);
      check({e.tag, ".rd"},     o.rd,     e.rd);
      check({e.tag, ".wr"},     o.wr,     e.wr);
      check({e.tag, ".wrx"},    o.wrx,    e.wrx);
      check({e.tag, ".ecx"},    o.ecx,    e.ecx);
      check({e.tag, ".atomic"}, o.atomic, e.atomic);
      check({e.tag, ".iack"},   o.iack,   e.iack);
      check({e.tag, ".gnt"},    o.gnt_or, e.gnt_or);
      $display("op %s: done=%0d at cycle %0d err=%0d", e.tag, o.dn, o.cyc, o.er);
   endtask

   task automatic post_done(input string tag);
      tick();
      check({tag, ".gnt_clear"},  gnt,  2'b00);
      check({tag, ".done_clear"}, done, 2'b00);
      check({tag, ".err_clear"},  err,  1'b0);
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, ".gnt"},     gnt,  2'b00);
      check({tag, ".done"},    done, 2'b00);
      check({tag, ".err"},     err,  1'b0);
      check({tag, ".arx"},     arx,  2'd2);
      check({tag, ".strobes"}, {ecx, astb, rd, wr, wrx, iack, atomic}, 7'd0);
   endtask

   initial begin
      repeat (3) tick();
      check_idle_outputs("reset");
      reset = 1'b0;
      tick();

      // Both channels request DRD: ch0 first, ch1 after ch0's FIN/IDLE.
      start(2'b11, OP_DRD, OP_DRD);
      sb_q.push_back(mk("drd_ch0", 4, 1, 0, 1, 1, 0, 1, 3, 0, 0, 1));
      sb_q.push_back(mk("drd_ch1", 4, 2, 0, 1, 1, 0, 1, 3, 0, 0, 2));
      verify(20);
      tick();
      verify(20);
      post_done("drd");

      start(2'b01, OP_BTRRD, 4'd0);
      sb_q.push_back(mk("btrrd", 10, 1, 0, 1, 4, 0, 4, 9, 0, 0, 1));
      verify(30);
      post_done("btrrd");

      stall_left = 3;
      start(2'b10, 4'd0, OP_RDMWR);
      sb_q.push_back(mk("rdmwr", 9, 2, 0, 1, 1, 1, 4, 8, 8, 0, 2));
      verify(30);
      post_done("rdmwr");

      // STROBE entered at cycle 3; timeout lands 256 cycles later.
      force_low = 1'b1;
      start(2'b01, OP_DWR, 4'd0);
      sb_q.push_back(mk("dwr_tmo", 259, 1, 1, 1, 0, 256, 0, 258, 0, 0, 1));
      verify(400);
      force_low = 1'b0;
      mem_ready = 1'b1;
      post_done("dwr_tmo");

      start(2'b10, 4'd0, 4'd14);
      sb_q.push_back(mk("op14", 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 2));
      verify(10);
      post_done("op14");

      start(2'b01, OP_BIRD, 4'd0);
      sb_q.push_back(mk("bird", 3, 1, 0, 0, 1, 0, 1, 2, 0, 2, 1));
      verify(10);
      post_done("bird");

      // Suspend in SETUP of burst word 2.
      start(2'b01, OP_BTRRD, 4'd0);
      repeat (4) tick();
      check("susp.rd_word2", rd, 1'b1);
      suspend = 1'b1;
      tick();
      suspend = 1'b0;
      req     = 2'b00;
      check_idle_outputs("susp");
      dacc = '0;
      for (int i = 0; i < 6; i++) begin
         tick();
         dacc = dacc | done;
      end
      check("susp.no_done", dacc, 2'b00);
      $display("op suspend: idle after suspend, done_seen=%0d", dacc);

      // ch0 was granted before the suspend, so ch1 now has priority.
      start(2'b11, OP_DRD, OP_DRD);
      sb_q.push_back(mk("rr_ch1", 4, 2, 0, 1, 1, 0, 1, 3, 0, 0, 2));
      sb_q.push_back(mk("rr_ch0", 4, 1, 0, 1, 1, 0, 1, 3, 0, 0, 1));
      verify(20);
      tick();
      verify(20);
      post_done("rr");

      // Reset while FETCH is in SETUP.
      start(2'b01, OP_FETCH, 4'd0);
      repeat (2) tick();
      check("fetch.arx_cmd", arx, 2'd1);
      check("fetch.rd", rd, 1'b1);
      reset = 1'b1;
      req   = 2'b00;
      tick();
      check_idle_outputs("midreset");
      reset = 1'b0;
      dacc  = '0;
      for (int i = 0; i < 4; i++) begin
         tick();
         dacc = dacc | done;
      end
      check("midreset.no_done", dacc, 2'b00);
      $display("op midreset: outputs at reset values, done_seen=%0d", dacc);

      // Pointer was reset, so ch0 wins again.
      start(2'b11, OP_FETCH, OP_FETCH);
      sb_q.push_back(mk("fetch_ch0", 4, 1, 0, 1, 1, 0, 1, 3, 0, 0, 1));
      sb_q.push_back(mk("fetch_ch1", 4, 2, 0, 1, 1, 0, 1, 3, 0, 0, 2));
      verify(20);
      tick();
      verify(20);
      post_done("fetch");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
